id_ex_issue: RTL and testbench

- Upstream end of the EX-stage operand interface in the 5-stage MIPS core.
- Holds the ID/EX pipeline register and drives `alu_op`, `mux41_input_1` and `mux41_input_2` into the EX-stage ALU.
- Resolves data forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles on stall or flush.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fwd_unit.sv | 29 ++
 rtl/id_ex_issue.sv | 139 +++++++++++++
 tb/tb_id_ex_issue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, opcode constants and forwarding-select encoding for the
// 5-stage MIPS core.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam int REG_W  = 5;

  localparam logic [OP_W-1:0] ALU_NOP = 6'd0;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_t;

endpackage

// File: rtl/fwd_unit.sv
// Picks the freshest source for one EX operand: EX/MEM beats MEM/WB, and
// register 0 is never forwarded because it is hard-wired to zero.
module fwd_unit
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0] i_addr,
  input  logic             i_exmem_reg_write,
  input  logic [REG_W-1:0] i_exmem_rd,
  input  logic             i_memwb_reg_write,
  input  logic [REG_W-1:0] i_memwb_rd,
  output fwd_sel_t         o_sel
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_exmem_hit = i_exmem_reg_write & (i_exmem_rd != '0) & (i_exmem_rd == i_addr);
  assign w_memwb_hit = i_memwb_reg_write & (i_memwb_rd != '0) & (i_memwb_rd == i_addr);

  always_comb begin
    o_sel = FWD_RF;
    if (w_exmem_hit) begin
      o_sel = FWD_EXMEM;
    end else if (w_memwb_hit) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register with load-use stall detection and EX operand
// forwarding; feeds the ALU operand muxes and the EX/MEM register.
module id_ex_issue
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic [REG_W-1:0]  id_rs_addr,
  input  logic [REG_W-1:0]  id_rt_addr,
  input  logic [REG_W-1:0]  id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] mux41_input_1,
  output logic [DATA_W-1:0] mux41_input_2,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_store_data
);

  logic              r_valid;
  logic [OP_W-1:0]   r_alu_op;
  logic [REG_W-1:0]  r_rs_addr;
  logic [REG_W-1:0]  r_rt_addr;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic              r_use_imm;
  logic              r_reg_write;
  logic              r_mem_read;

  logic              w_load_use;
  logic              w_bubble;
  fwd_sel_t          w_rs_sel;
  fwd_sel_t          w_rt_sel;
  logic [DATA_W-1:0] w_rs_fwd;
  logic [DATA_W-1:0] w_rt_fwd;

  // A load in EX cannot feed the instruction in ID this cycle; an immediate
  // operand 2 means rt is only a destination and cannot cause the hazard.
  assign w_load_use = id_valid & r_valid & r_mem_read & (r_rd != '0) &
                      ((r_rd == id_rs_addr) | ((r_rd == id_rt_addr) & ~id_use_imm));

  assign stall_id = rst_n & ~flush & (w_load_use | ex_hold);
  assign w_bubble = ~rst_n | flush | (~ex_hold & w_load_use);

  always_ff @(posedge clk) begin
    if (w_bubble) begin
      r_valid     <= 1'b0;
      r_alu_op    <= ALU_NOP;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd        <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (!ex_hold) begin
      r_valid     <= id_valid;
      r_alu_op    <= id_alu_op;
      r_rs_addr   <= id_rs_addr;
      r_rt_addr   <= id_rt_addr;
      r_rd        <= id_rd_addr;
      r_rs_data   <= id_rs_data;
      r_rt_data   <= id_rt_data;
      r_imm       <= id_imm;
      r_use_imm   <= id_use_imm;
      r_reg_write <= id_reg_write;
      r_mem_read  <= id_mem_read;
    end
  end

  fwd_unit u_fwd_rs (
    .i_addr            (r_rs_addr),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .o_sel             (w_rs_sel)
  );

  fwd_unit u_fwd_rt (
    .i_addr            (r_rt_addr),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .o_sel             (w_rt_sel)
  );

  always_comb begin
    w_rs_fwd = r_rs_data;
    case (w_rs_sel)
      FWD_EXMEM: w_rs_fwd = exmem_result;
      FWD_MEMWB: w_rs_fwd = memwb_result;
      default:   w_rs_fwd = r_rs_data;
    endcase
  end

  always_comb begin
    w_rt_fwd = r_rt_data;
    case (w_rt_sel)
      FWD_EXMEM: w_rt_fwd = exmem_result;
      FWD_MEMWB: w_rt_fwd = memwb_result;
      default:   w_rt_fwd = r_rt_data;
    endcase
  end

  // Operands read zero for an empty slot so a bubble never presents stale data.
  assign ex_valid      = r_valid;
  assign alu_op        = r_alu_op;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign mux41_input_1 = r_valid ? w_rs_fwd : '0;
  assign mux41_input_2 = !r_valid ? '0 : (r_use_imm ? r_imm : w_rt_fwd);
  assign ex_store_data = r_valid ? w_rt_fwd : '0;

endmodule

// File: tb/tb_id_ex_issue.sv
// Self-checking bench for id_ex_issue: directed hazard/forwarding scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_id_ex_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_alu_op;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm, id_reg_write, id_mem_read;
  logic        flush, ex_hold;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        stall_id, ex_valid, ex_reg_write, ex_mem_read;
  logic [5:0]  alu_op;
  logic [4:0]  ex_rd;
  logic [31:0] mux41_input_1, mux41_input_2, ex_store_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_issue dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .ex_hold(ex_hold),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall_id(stall_id), .ex_valid(ex_valid), .alu_op(alu_op),
    .mux41_input_1(mux41_input_1), .mux41_input_2(mux41_input_2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_store_data(ex_store_data)
  );

  // Reference model: the instruction currently sitting in EX, or an empty slot.
  typedef struct packed {
    logic        v;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic        ui, rw, mr;
  } slot_t;

  slot_t m = '0;

  function automatic logic modelLoadUse();
    if (!(id_valid && m.v && m.mr && m.rd != 0)) return 1'b0;
    return (m.rd == id_rs_addr) || (m.rd == id_rt_addr && !id_use_imm);
  endfunction

  function automatic logic [31:0] fwdVal(input logic [4:0] addr, input logic [31:0] rf);
    if (addr == 0) return rf;
    if (exmem_reg_write && exmem_rd == addr) return exmem_result;
    if (memwb_reg_write && memwb_rd == addr) return memwb_result;
    return rf;
  endfunction

  always @(posedge clk) begin
    if (!rst_n || flush) m <= '0;
    else if (ex_hold) m <= m;
    else if (modelLoadUse()) m <= '0;
    else m <= '{id_valid, id_alu_op, id_rs_addr, id_rt_addr, id_rd_addr,
                id_rs_data, id_rt_data, id_imm, id_use_imm, id_reg_write, id_mem_read};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] op,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                               input logic ui, input logic rw, input logic mr);
    id_valid = v; id_alu_op = op; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_use_imm = ui; id_reg_write = rw; id_mem_read = mr;
  endtask

  // Every-cycle comparison of all outputs against the model.
  initial begin
    logic [31:0] e1, e2, es;
    logic        est;
    @(posedge clk);
    forever begin
      @(negedge clk);
      est = rst_n && !flush && (modelLoadUse() || ex_hold);
      e1  = m.v ? fwdVal(m.rs, m.rsd) : 32'h0;
      e2  = !m.v ? 32'h0 : (m.ui ? m.imm : fwdVal(m.rt, m.rtd));
      es  = m.v ? fwdVal(m.rt, m.rtd) : 32'h0;
      checkOutput("model_stall_id", 32'(stall_id), 32'(est));
      checkOutput("model_ex_valid", 32'(ex_valid), 32'(m.v));
      checkOutput("model_alu_op", 32'(alu_op), 32'(m.op));
      checkOutput("model_ex_rd", 32'(ex_rd), 32'(m.rd));
      checkOutput("model_reg_write", 32'(ex_reg_write), 32'(m.rw));
      checkOutput("model_mem_read", 32'(ex_mem_read), 32'(m.mr));
      checkOutput("model_mux1", mux41_input_1, e1);
      checkOutput("model_mux2", mux41_input_2, e2);
      checkOutput("model_store", ex_store_data, es);
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'h0;
    applyStimulus(1, 6'h20, 1, 2, 3, 32'h5, 32'h7, 32'h0, 0, 1, 0);

    // Reset with a valid instruction waiting in ID
    nextCycle(); @(negedge clk);
    checkOutput("rst_ex_valid", 32'(ex_valid), 32'h0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'h0);
    checkOutput("rst_mux1", mux41_input_1, 32'h0);
    checkOutput("rst_stall", 32'(stall_id), 32'h0);
    nextCycle(); @(negedge clk);
    checkOutput("rst_ex_valid2", 32'(ex_valid), 32'h0);
    checkOutput("rst_store", ex_store_data, 32'h0);
    nextCycle();
    rst_n = 1'b1;

    // add $3 <- $1 + $2, then sub $4 <- $3 - $1 with $3 forwarded from EX/MEM
    nextCycle();
    applyStimulus(1, 6'h22, 3, 1, 4, 32'h99, 32'h5, 32'h0, 0, 1, 0);
    @(negedge clk);
    checkOutput("add_ex_valid", 32'(ex_valid), 32'h1);
    checkOutput("add_mux1", mux41_input_1, 32'h5);
    checkOutput("add_mux2", mux41_input_2, 32'h7);
    checkOutput("add_ex_rd", 32'(ex_rd), 32'h3);
    nextCycle();
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h10;
    applyStimulus(1, 6'h20, 5, 6, 7, 32'h55, 32'h66, 32'h0, 0, 1, 0);
    @(negedge clk);
    checkOutput("sub_alu_op", 32'(alu_op), 32'h22);
    checkOutput("sub_fwd_exmem", mux41_input_1, 32'h10);
    checkOutput("sub_mux2", mux41_input_2, 32'h5);

    // Both writeback ports match: EX/MEM wins; register 0 is never forwarded
    nextCycle();
    exmem_rd = 5'd5; exmem_result = 32'hA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hB;
    applyStimulus(1, 6'h20, 0, 6, 7, 32'h77, 32'h66, 32'h0, 0, 1, 0);
    @(negedge clk);
    checkOutput("double_match", mux41_input_1, 32'hA);
    nextCycle();
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    applyStimulus(1, 6'h23, 1, 2, 2, 32'h0, 32'h0, 32'h4, 1, 1, 1);
    @(negedge clk);
    checkOutput("reg0_no_fwd", mux41_input_1, 32'h77);

    // lw $2 in EX, add uses $2: one bubble, then issue with MEM/WB value
    nextCycle();
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
    applyStimulus(1, 6'h20, 2, 3, 5, 32'h1111, 32'h3333, 32'h0, 0, 1, 0);
    @(negedge clk);
    checkOutput("lu_stall", 32'(stall_id), 32'h1);
    nextCycle();
    memwb_reg_write = 1'b1; memwb_rd = 5'd2; memwb_result = 32'hDEAD;
    @(negedge clk);
    checkOutput("lu_bubble_valid", 32'(ex_valid), 32'h0);
    checkOutput("lu_bubble_regwr", 32'(ex_reg_write), 32'h0);
    checkOutput("lu_stall_once", 32'(stall_id), 32'h0);
    nextCycle();
    applyStimulus(1, 6'h23, 1, 2, 2, 32'h0, 32'h0, 32'h8, 1, 1, 1);
    @(negedge clk);
    checkOutput("lu_issue_valid", 32'(ex_valid), 32'h1);
    checkOutput("lu_issue_mux1", mux41_input_1, 32'hDEAD);
    checkOutput("lu_issue_mux2", mux41_input_2, 32'h3333);

    // lw $2 in EX, addi with rt=$2 as immediate target: no stall
    nextCycle();
    memwb_reg_write = 1'b0;
    applyStimulus(1, 6'h08, 4, 2, 2, 32'h44, 32'h42, 32'h1234, 1, 1, 0);
    @(negedge clk);
    checkOutput("imm_no_stall", 32'(stall_id), 32'h0);
    nextCycle();
    exmem_reg_write = 1'b1; exmem_rd = 5'd2; exmem_result = 32'hBEEF;
    applyStimulus(1, 6'h25, 1, 2, 3, 32'h10, 32'h20, 32'h0, 0, 1, 0);
    @(negedge clk);
    checkOutput("imm_valid", 32'(ex_valid), 32'h1);
    checkOutput("imm_mux1", mux41_input_1, 32'h44);
    checkOutput("imm_mux2", mux41_input_2, 32'h1234);
    checkOutput("imm_store_fwd", ex_store_data, 32'hBEEF);

    // Flush overrides hold; then a plain hold freezes EX for 3 cycles
    nextCycle();
    exmem_reg_write = 1'b0; flush = 1'b1; ex_hold = 1'b1;
    @(negedge clk);
    checkOutput("flush_stall", 32'(stall_id), 32'h0);
    nextCycle();
    flush = 1'b0; ex_hold = 1'b0;
    applyStimulus(1, 6'h2A, 1, 2, 3, 32'h100, 32'h200, 32'h0, 0, 1, 0);
    @(negedge clk);
    checkOutput("flush_valid", 32'(ex_valid), 32'h0);
    checkOutput("flush_alu_op", 32'(alu_op), 32'h0);
    nextCycle();
    ex_hold = 1'b1;
    applyStimulus(1, 6'h20, 3, 3, 3, 32'h1, 32'h1, 32'h0, 0, 1, 0);
    @(negedge clk);
    checkOutput("hold_stall", 32'(stall_id), 32'h1);
    for (int i = 0; i < 3; i++) begin
      nextCycle(); @(negedge clk);
      checkOutput("hold_alu_op", 32'(alu_op), 32'h2A);
      checkOutput("hold_mux1", mux41_input_1, 32'h100);
      checkOutput("hold_stall_n", 32'(stall_id), 32'h1);
    end
    nextCycle();
    ex_hold = 1'b0;

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      nextCycle();
      rst_n           = ($urandom_range(0, 39) != 0);
      flush           = ($urandom_range(0, 9) == 0);
      ex_hold         = ($urandom_range(0, 7) == 0);
      exmem_reg_write = 1'($urandom_range(0, 1));
      exmem_rd        = 5'($urandom_range(0, 3));
      exmem_result    = $urandom;
      memwb_reg_write = 1'($urandom_range(0, 1));
      memwb_rd        = 5'($urandom_range(0, 3));
      memwb_result    = $urandom;
      applyStimulus(($urandom_range(0, 7) != 0), 6'($urandom),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    $urandom, $urandom, $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end
    nextCycle();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
